// File: rtl/image_pkg.sv
// Shared image-path definitions: BRAM geometry, pixel packing and FSM state encodings
// used by the loader and the frame sender.
package image_pkg;
  localparam int ADDR_W     = 19;
  localparam int PIX_W      = 18;
  localparam int COLOR_W    = 6;
  localparam int DEF_PIXELS = 276185;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_WAIT, ST_SEND, ST_NEXT, ST_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  // Colour idx of a packed pixel, widened to a byte with zero LSBs; idx 0 is the MSB field.
  function automatic logic [7:0] colour_byte(input logic [PIX_W-1:0] px, input logic [1:0] idx);
    case (idx)
      2'd0:    return {px[17:12], 2'b00};
      2'd1:    return {px[11:6], 2'b00};
      default: return {px[5:0], 2'b00};
    endcase
  endfunction
endpackage

// File: rtl/frame_uart_sender_uart_tx.sv
// 8N1 UART transmitter, mirror of the receiver: start bit, 8 data bits LSB first, stop bit.
module uart_tx
  import image_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
  // Combinational so the pulse lands in the last cycle of the stop bit itself.
  assign tx_done = (state == TX_STOP) && bit_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= TX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt <= '0;
          if (tx_start) begin
            shreg     <= tx_byte;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            cnt       <= '0;
            bit_idx   <= '0;
            tx_serial <= shreg[0];
            shreg     <= shreg >> 1;
            state     <= TX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        TX_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_serial <= 1'b1;
              state     <= TX_STOP;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx_serial <= shreg[0];
              shreg     <= shreg >> 1;
            end
          end else cnt <= cnt + 1'b1;
        end
        TX_STOP: begin
          if (bit_end) begin
            cnt     <= '0;
            tx_busy <= 1'b0;
            state   <= TX_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/frame_uart_sender.sv
// Reads a processed frame from pixel BRAM port B and streams each pixel as three
// colour bytes over UART; raises done after the last stop bit.
module frame_uart_sender
  import image_pkg::*;
#(
  parameter int PIXELS       = DEF_PIXELS,
  parameter int CLKS_PER_BIT = 100,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] r_address,
  input  logic [PIX_W-1:0]  r_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  frame_state_t     state;
  logic [1:0]       lat_cnt;
  logic [PIX_W-1:0] pix;
  logic [1:0]       byte_idx;
  logic             sent;
  logic             tx_start;
  logic [7:0]       tx_byte;
  logic             tx_busy;
  logic             tx_done;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_serial(uart_tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rd_en     <= 1'b0;
      r_address <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lat_cnt   <= '0;
      pix       <= '0;
      byte_idx  <= '0;
      sent      <= 1'b0;
      tx_start  <= 1'b0;
      tx_byte   <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            done      <= 1'b0;
            busy      <= 1'b1;
            r_address <= '0;
            rd_en     <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          rd_en   <= 1'b0;
          lat_cnt <= 2'd1;
          state   <= ST_WAIT;
        end
        // lat_cnt counts cycles since the enable cycle; exit when the word is valid.
        ST_WAIT: begin
          if (lat_cnt == 2'(READ_LATENCY)) begin
            pix      <= r_data;
            byte_idx <= '0;
            sent     <= 1'b0;
            state    <= ST_SEND;
          end else lat_cnt <= lat_cnt + 1'b1;
        end
        ST_SEND: begin
          if (!sent) begin
            if (!tx_busy) begin
              tx_start <= 1'b1;
              tx_byte  <= colour_byte(pix, byte_idx);
              sent     <= 1'b1;
            end
          end else if (tx_done) begin
            sent <= 1'b0;
            if (byte_idx == 2'd2) state <= ST_NEXT;
            else byte_idx <= byte_idx + 1'b1;
          end
        end
        ST_NEXT: begin
          if (r_address == LAST_ADDR) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            r_address <= r_address + 1'b1;
            rd_en     <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_uart_sender.sv
// Three senders (1 pixel RL=2, 4 pixels RL=1, 4 pixels RL=3) with BRAM models and a
// UART line decoder per instance; directed scenarios check bytes, addresses and timing.
module tb_frame_uart_sender;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start     [3];
  logic        rd_en     [3];
  logic [18:0] r_address [3];
  logic [17:0] r_data    [3];
  logic        uart_tx   [3];
  logic        busy      [3];
  logic        done      [3];

  logic [17:0] mem  [3][4];
  logic [17:0] pipe [3][3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rl_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input int n);
    logic [17:0] w;
    w = mem[i][n / 3];
    case (n % 3)
      0:       return {w[17:12], 2'b00};
      1:       return {w[11:6], 2'b00};
      default: return {w[5:0], 2'b00};
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    frame_uart_sender #(
      .PIXELS(g == 0 ? 1 : 4), .CLKS_PER_BIT(CPB),
      .READ_LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start[g]), .rd_en(rd_en[g]),
      .r_address(r_address[g]), .r_data(r_data[g]), .uart_tx(uart_tx[g]),
      .busy(busy[g]), .done(done[g])
    );
  end

  // BRAM model: a garbage word enters the pipe whenever rd_en is low.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pipe[i][0] <= rd_en[i] ? mem[i][r_address[i][1:0]] : (18'h2AAAA ^ 18'(cyc));
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  always_comb begin
    for (int i = 0; i < 3; i++) r_data[i] = pipe[i][rl_of(i) - 1];
  end

  // Line decoder and bus monitor, sampled on the falling edge.
  logic [7:0]  rx_bytes [3][64];
  logic [18:0] rd_addr  [3][16];
  int rx_n[3] = '{0, 0, 0};
  int rd_n[3] = '{0, 0, 0};
  int bit_err[3] = '{0, 0, 0};
  int gap_err[3] = '{0, 0, 0};
  int done_rise[3] = '{0, 0, 0};
  int done_cyc[3] = '{0, 0, 0};
  int last_stop[3] = '{0, 0, 0};
  int dcnt[3] = '{0, 0, 0};
  bit dst[3] = '{0, 0, 0};
  bit armed[3] = '{0, 0, 0};
  bit saw_rd[3] = '{0, 0, 0};
  logic prev_done[3] = '{0, 0, 0};
  logic bitval[3] = '{0, 0, 0};
  logic [7:0] shreg[3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        dst[i]   <= 1'b0;
        armed[i] <= 1'b0;
      end else begin
        if (done[i] && !prev_done[i]) begin
          done_rise[i] <= done_rise[i] + 1;
          done_cyc[i]  <= cyc;
          armed[i]     <= 1'b0;
        end
        prev_done[i] <= done[i];
        if (!dst[i]) begin
          if (uart_tx[i] === 1'b0) begin
            dst[i]    <= 1'b1;
            dcnt[i]   <= 1;
            bitval[i] <= 1'b0;
            saw_rd[i] <= 1'b0;
            if (armed[i] && (cyc - last_stop[i] - 1 > (saw_rd[i] ? rl_of(i) + 4 : 2)))
              gap_err[i] <= gap_err[i] + 1;
          end
        end else begin
          if (dcnt[i] % CPB == 0) bitval[i] <= uart_tx[i];
          else if (uart_tx[i] !== bitval[i]) bit_err[i] <= bit_err[i] + 1;
          if (dcnt[i] / CPB == 9 && uart_tx[i] !== 1'b1) bit_err[i] <= bit_err[i] + 1;
          if (dcnt[i] % CPB == CPB / 2 && dcnt[i] / CPB >= 1 && dcnt[i] / CPB <= 8)
            shreg[i] <= {uart_tx[i], shreg[i][7:1]};
          if (dcnt[i] == 10 * CPB - 1) begin
            dst[i] <= 1'b0;
            rx_bytes[i][rx_n[i] & 63] <= shreg[i];
            rx_n[i]      <= rx_n[i] + 1;
            last_stop[i] <= cyc;
            armed[i]     <= 1'b1;
          end
          dcnt[i] <= dcnt[i] + 1;
        end
        if (rd_en[i]) begin
          rd_addr[i][rd_n[i] & 15] <= r_address[i];
          rd_n[i]   <= rd_n[i] + 1;
          saw_rd[i] <= 1'b1;
        end
      end
    end
  end

  task automatic pulse(input int i, output int t);
    @(negedge clk);
    start[i] = 1'b1;
    t = cyc;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done[i] === 1'b1) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (uart_tx[i] !== 1'b1) begin errors++; $display("FAIL reset_uart_tx[%0d] got %b want 1", i, uart_tx[i]); end
      checks++; if (rd_en[i] !== 1'b0) begin errors++; $display("FAIL reset_rd_en[%0d] got %b want 0", i, rd_en[i]); end
      checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", i, busy[i]); end
      checks++; if (done[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %b want 0", i, done[i]); end
      checks++; if (r_address[i] !== 19'd0) begin errors++; $display("FAIL reset_addr[%0d] got %0h want 0", i, r_address[i]); end
    end
  endtask

  task automatic test_single_pixel;
    int t, f, b, r, dr, e, g;
    bit ok;
    logic [7:0] want[3] = '{8'hFC, 8'h00, 8'h54};
    b = rx_n[0]; r = rd_n[0]; dr = done_rise[0]; e = bit_err[0]; g = gap_err[0];
    pulse(0, t);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_t1 got %b want 1", busy[0]); end
    checks++; if (rd_en[0] !== 1'b1) begin errors++; $display("FAIL single_rd_en_t1 got %b want 1", rd_en[0]); end
    checks++; if (r_address[0] !== 19'd0) begin errors++; $display("FAIL single_addr_t1 got %0h want 0", r_address[0]); end
    f = -1;
    for (int k = 0; k < 12; k++) begin
      if (uart_tx[0] === 1'b0) begin f = cyc; break; end
      @(negedge clk);
    end
    checks++; if (f < 0 || f - t > 6) begin errors++; $display("FAIL single_first_start_bit got %0d want <=6 cycles", f - t); end
    wait_done(0, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got 0 want 1"); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_at_done got %b want 0", busy[0]); end
    checks++; if (rx_n[0] - b != 3) begin errors++; $display("FAIL single_byte_count got %0d want 3", rx_n[0] - b); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (rx_bytes[0][(b + k) & 63] !== want[k]) begin errors++; $display("FAIL single_byte%0d got %02h want %02h", k, rx_bytes[0][(b + k) & 63], want[k]); end
    end
    checks++; if (rd_n[0] - r != 1) begin errors++; $display("FAIL single_rd_count got %0d want 1", rd_n[0] - r); end
    checks++; if (rd_addr[0][r & 15] !== 19'd0) begin errors++; $display("FAIL single_rd_addr got %0h want 0", rd_addr[0][r & 15]); end
    checks++; if (done_cyc[0] - last_stop[0] < 1 || done_cyc[0] - last_stop[0] > 2) begin errors++; $display("FAIL single_done_latency got %0d want 1..2", done_cyc[0] - last_stop[0]); end
    checks++; if (bit_err[0] != e || gap_err[0] != g) begin errors++; $display("FAIL single_line_timing got bit=%0d gap=%0d want 0 0", bit_err[0] - e, gap_err[0] - g); end
    checks++; if (done_rise[0] - dr != 1) begin errors++; $display("FAIL single_done_rises got %0d want 1", done_rise[0] - dr); end
  endtask

  task automatic test_multi_pixel;
    int b[3], r[3], dr[3], e[3], g[3];
    bit ok1, ok2;
    for (int i = 1; i < 3; i++) begin
      b[i] = rx_n[i]; r[i] = rd_n[i]; dr[i] = done_rise[i]; e[i] = bit_err[i]; g[i] = gap_err[i];
    end
    @(negedge clk); start[1] = 1'b1; start[2] = 1'b1;
    @(negedge clk); start[1] = 1'b0; start[2] = 1'b0;
    wait_done(1, 1000, ok1);
    wait_done(2, 1000, ok2);
    repeat (20) @(negedge clk);
    for (int i = 1; i < 3; i++) begin
      checks++; if (!(i == 1 ? ok1 : ok2)) begin errors++; $display("FAIL multi_done_timeout[%0d] got 0 want 1", i); end
      checks++; if (rx_n[i] - b[i] != 12) begin errors++; $display("FAIL multi_byte_count[%0d] got %0d want 12", i, rx_n[i] - b[i]); end
      for (int k = 0; k < 12; k++) begin
        checks++; if (rx_bytes[i][(b[i] + k) & 63] !== exp_byte(i, k)) begin errors++; $display("FAIL multi_byte[%0d][%0d] got %02h want %02h", i, k, rx_bytes[i][(b[i] + k) & 63], exp_byte(i, k)); end
      end
      checks++; if (rd_n[i] - r[i] != 4) begin errors++; $display("FAIL multi_rd_count[%0d] got %0d want 4", i, rd_n[i] - r[i]); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (rd_addr[i][(r[i] + k) & 15] !== 19'(k)) begin errors++; $display("FAIL multi_rd_addr[%0d][%0d] got %0h want %0h", i, k, rd_addr[i][(r[i] + k) & 15], k); end
      end
      checks++; if (bit_err[i] != e[i] || gap_err[i] != g[i]) begin errors++; $display("FAIL multi_line_timing[%0d] got bit=%0d gap=%0d want 0 0", i, bit_err[i] - e[i], gap_err[i] - g[i]); end
      checks++; if (done_rise[i] - dr[i] != 1) begin errors++; $display("FAIL multi_done_rises[%0d] got %0d want 1", i, done_rise[i] - dr[i]); end
    end
  endtask

  task automatic test_start_ignored;
    int t, b, r, dr;
    bit ok;
    b = rx_n[2]; r = rd_n[2]; dr = done_rise[2];
    pulse(2, t);
    for (int k = 0; k < 1000 && rx_n[2] - b < 7; k++) @(negedge clk);
    for (int k = 0; k < 20 && !dst[2]; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    checks++; if (busy[2] !== 1'b1 || rd_en[2] !== 1'b0) begin errors++; $display("FAIL ignored_state got busy=%b rd_en=%b want 1 0", busy[2], rd_en[2]); end
    wait_done(2, 1000, ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL ignored_done_timeout got 0 want 1"); end
    checks++; if (rx_n[2] - b != 12) begin errors++; $display("FAIL ignored_byte_count got %0d want 12", rx_n[2] - b); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (rx_bytes[2][(b + k) & 63] !== exp_byte(2, k)) begin errors++; $display("FAIL ignored_byte[%0d] got %02h want %02h", k, rx_bytes[2][(b + k) & 63], exp_byte(2, k)); end
    end
    checks++; if (rd_n[2] - r != 4) begin errors++; $display("FAIL ignored_rd_count got %0d want 4", rd_n[2] - r); end
    checks++; if (done_rise[2] - dr != 1) begin errors++; $display("FAIL ignored_done_rises got %0d want 1", done_rise[2] - dr); end
  endtask

  task automatic test_back_to_back;
    int t, b, r;
    bit ok;
    b = rx_n[1]; r = rd_n[1];
    checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL b2b_done_before got %b want 1", done[1]); end
    pulse(1, t);
    checks++; if (done[1] !== 1'b0 || busy[1] !== 1'b1) begin errors++; $display("FAIL b2b_restart got done=%b busy=%b want 0 1", done[1], busy[1]); end
    wait_done(1, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout got 0 want 1"); end
    checks++; if (rx_n[1] - b != 12) begin errors++; $display("FAIL b2b_byte_count got %0d want 12", rx_n[1] - b); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (rx_bytes[1][(b + k) & 63] !== exp_byte(1, k)) begin errors++; $display("FAIL b2b_byte[%0d] got %02h want %02h", k, rx_bytes[1][(b + k) & 63], exp_byte(1, k)); end
    end
    checks++; if (rd_n[1] - r != 4) begin errors++; $display("FAIL b2b_rd_count got %0d want 4", rd_n[1] - r); end
  endtask

  task automatic test_reset_mid;
    int t, b, r;
    bit ok;
    b = rx_n[1];
    pulse(1, t);
    for (int k = 0; k < 600 && rx_n[1] - b < 3; k++) @(negedge clk);
    for (int k = 0; k < 20 && !dst[1]; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (uart_tx[1] !== 1'b1) begin errors++; $display("FAIL midreset_uart_tx got %b want 1", uart_tx[1]); end
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy[1]); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (rx_n[1] - b != 3 || busy[1] !== 1'b0) begin errors++; $display("FAIL midreset_quiet got bytes=%0d busy=%b want 3 0", rx_n[1] - b, busy[1]); end
    b = rx_n[1]; r = rd_n[1];
    pulse(1, t);
    wait_done(1, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_done_timeout got 0 want 1"); end
    checks++; if (rx_n[1] - b != 12) begin errors++; $display("FAIL midreset_byte_count got %0d want 12", rx_n[1] - b); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (rx_bytes[1][(b + k) & 63] !== exp_byte(1, k)) begin errors++; $display("FAIL midreset_byte[%0d] got %02h want %02h", k, rx_bytes[1][(b + k) & 63], exp_byte(1, k)); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_addr[1][(r + k) & 15] !== 19'(k)) begin errors++; $display("FAIL midreset_rd_addr[%0d] got %0h want %0h", k, rd_addr[1][(r + k) & 15], k); end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    mem[0] = '{18'h3F015, 18'h0, 18'h0, 18'h0};
    mem[1] = '{18'h12345, 18'h0ABCD, 18'h3FFC0, 18'h2D2D2};
    mem[2] = '{18'h15A5A, 18'h00001, 18'h20000, 18'h3FFFF};
    test_reset;
    test_single_pixel;
    test_multi_pixel;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
